// File: rtl/cond_unit.sv
// Conditional-execution stage: holds the NZCV flag register, evaluates the
// instruction condition field and gates the decoder write strobes.
module cond_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         NV_EXECUTES = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx
);

  localparam int unsigned FLAG_W = 4;

  logic [FLAG_W-1:0] flags_q;
  logic              n_f, z_f, c_f, v_f;
  logic              cond_ex_c;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Condition evaluation on the stored flags (read-before-write)
  always_comb begin
    cond_ex_c = 1'b0;
    case (Cond)
      4'b0000: cond_ex_c = z_f;
      4'b0001: cond_ex_c = ~z_f;
      4'b0010: cond_ex_c = c_f;
      4'b0011: cond_ex_c = ~c_f;
      4'b0100: cond_ex_c = n_f;
      4'b0101: cond_ex_c = ~n_f;
      4'b0110: cond_ex_c = v_f;
      4'b0111: cond_ex_c = ~v_f;
      4'b1000: cond_ex_c = c_f & ~z_f;
      4'b1001: cond_ex_c = ~c_f | z_f;
      4'b1010: cond_ex_c = (n_f == v_f);
      4'b1011: cond_ex_c = (n_f != v_f);
      4'b1100: cond_ex_c = ~z_f & (n_f == v_f);
      4'b1101: cond_ex_c = z_f | (n_f != v_f);
      4'b1110: cond_ex_c = 1'b1;
      default: cond_ex_c = NV_EXECUTES;
    endcase
  end

  // Flag register; each group loads independently, only on a passed condition
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= RESET_FLAGS;
    end else if (en && cond_ex_c) begin
      if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  assign CondEx   = cond_ex_c;
  assign Flags    = flags_q;
  assign PCSrc    = PCS  & cond_ex_c & en;
  assign RegWrite = RegW & cond_ex_c & en & ~NoWrite;
  assign MemWrite = MemW & cond_ex_c & en;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed vector table, async reset
// sequences and a full Cond x NZCV sweep for both NV_EXECUTES settings.
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;

  logic       pcsrc0, regwrite0, memwrite0, condex0;
  logic [3:0] flags0;
  logic       pcsrc1, regwrite1, memwrite1, condex1;
  logic [3:0] flags1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cond_unit #(.RESET_FLAGS(4'b0000), .NV_EXECUTES(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(pcsrc0), .RegWrite(regwrite0), .MemWrite(memwrite0),
    .Flags(flags0), .CondEx(condex0)
  );

  cond_unit #(.RESET_FLAGS(4'b0000), .NV_EXECUTES(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(pcsrc1), .RegWrite(regwrite1), .MemWrite(memwrite1),
    .Flags(flags1), .CondEx(condex1)
  );

  typedef struct {
    logic       en;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] flagw;
    logic       pcs, regw, memw, nowrite;
    logic       e_pcsrc, e_regwrite, e_memwrite, e_condex;
    logic [3:0] e_flags;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f, input logic nv);
    logic n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cc;
      4'h3: return !cc;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cc && !z;
      4'h9: return !cc || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return nv;
    endcase
  endfunction

  task automatic drive(input logic e, input logic [3:0] c, input logic [3:0] a,
                       input logic [1:0] fw, input logic p, input logic r,
                       input logic m, input logic nw);
    en = e; Cond = c; ALUFlags = a; FlagW = fw;
    PCS = p; RegW = r; MemW = m; NoWrite = nw;
  endtask

  initial begin
    // en cond alu flagw pcs regw memw nowr | pcsrc regw memw condex | flags after edge
    vecs[0]  = '{1'b1, 4'b1110, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110}; // CMP
    vecs[1]  = '{1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0110}; // BEQ
    vecs[2]  = '{1'b1, 4'b1110, 4'b1001, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1001};
    vecs[3]  = '{1'b1, 4'b1110, 4'b0110, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0101}; // split NZ
    vecs[4]  = '{1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100};
    vecs[5]  = '{1'b1, 4'b0001, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100}; // NE fails
    vecs[6]  = '{1'b0, 4'b1110, 4'b1011, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100}; // stall
    vecs[7]  = '{1'b1, 4'b1110, 4'b1011, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1011}; // resume
    vecs[8]  = '{1'b1, 4'b1110, 4'b0100, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000}; // split CV
    vecs[9]  = '{1'b1, 4'b1100, 4'b0000, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000}; // GT fails
    vecs[10] = '{1'b1, 4'b1011, 4'b0010, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010}; // LT
    vecs[11] = '{1'b1, 4'b1000, 4'b0110, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110}; // HI
    vecs[12] = '{1'b1, 4'b1001, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110}; // LS, NoWrite

    reset_n = 1'b0;
    drive(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("reset_flags0", 32'(flags0), 32'h0);
    chk("reset_flags1", 32'(flags1), 32'h0);
    chk("reset_eq_condex", 32'(condex0), 32'h0);
    #9 reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].en, vecs[i].cond, vecs[i].alu, vecs[i].flagw,
            vecs[i].pcs, vecs[i].regw, vecs[i].memw, vecs[i].nowrite);
      #1;
      chk($sformatf("v%0d_condex", i),   32'(condex0),   32'(vecs[i].e_condex));
      chk($sformatf("v%0d_pcsrc", i),    32'(pcsrc0),    32'(vecs[i].e_pcsrc));
      chk($sformatf("v%0d_regwrite", i), 32'(regwrite0), 32'(vecs[i].e_regwrite));
      chk($sformatf("v%0d_memwrite", i), 32'(memwrite0), 32'(vecs[i].e_memwrite));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_flags0", i), 32'(flags0), 32'(vecs[i].e_flags));
      chk($sformatf("v%0d_flags1", i), 32'(flags1), 32'(vecs[i].e_flags));
    end

    // Async reset asserted mid-cycle, flags 0110 -> 0000 with no clock edge
    @(posedge clk);
    #2;
    drive(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("pre_reset_eq_condex", 32'(condex0), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async_flags0", 32'(flags0), 32'h0);
    chk("async_flags1", 32'(flags1), 32'h0);
    chk("async_condex", 32'(condex0), 32'h0);
    chk("async_pcsrc", 32'(pcsrc0), 32'h0);

    // Reset released mid-cycle: first edge acts normally on the reset flags
    @(negedge clk);
    #2 reset_n = 1'b1;
    drive(1'b1, 4'b0000, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 chk("post_reset_eq_noupd", 32'(flags0), 32'h0);
    @(negedge clk);
    drive(1'b1, 4'b1110, 4'b0101, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 chk("post_reset_cv_upd", 32'(flags0), 32'h1);

    // Full sweep of Cond against every stored NZCV, both NV settings
    for (int f = 0; f < 16; f++) begin
      @(negedge clk);
      drive(1'b1, 4'b1110, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      en = 1'b0;
      chk($sformatf("sweep_load0_%0h", f), 32'(flags0), 32'(f));
      chk($sformatf("sweep_load1_%0h", f), 32'(flags1), 32'(f));
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c);
        #1;
        chk($sformatf("sweep_nv0_c%0h_f%0h", c, f), 32'(condex0),
            32'(cond_model(4'(c), 4'(f), 1'b0)));
        chk($sformatf("sweep_nv1_c%0h_f%0h", c, f), 32'(condex1),
            32'(cond_model(4'(c), 4'(f), 1'b1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
